mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//  Shares one pipelined signed fixed-point multiplier (Q8.24 x Q8.24 -> Q8.24)
//  between N_REQ requesters in the UKF datapath (sigma-point, covariance and
//  gain units). It arbitrates round-robin, tags each product with its
//  requester ID and returns a saturated result at a fixed latency.
//  Throughput is one multiply per cycle.
// PARAMETERS
//  DATA_W      32  operand/result width, two's complement
//  FRAC_BITS   24  fractional bits (INT_BITS = DATA_W-FRAC_BITS, incl. sign)
//  N_REQ       4   number of requesters, 2..8
//  PIPE_STAGES 2   accept-to-response latency in clock edges, 1..4
//  ID_W        $clog2(N_REQ)  requester tag width
// PORTS
//  clk        in   1             clock, rising edge
//  rst_n      in   1             asynchronous active-low reset
//  req_valid  in   N_REQ         per-requester operand valid
//  req_ready  out  N_REQ         one-hot grant; handshake = valid & ready
//  req_a      in   N_REQ*DATA_W  packed operand A, requester i at [i*DATA_W +: DATA_W]
//  req_b      in   N_REQ*DATA_W  packed operand B, same packing
//  rsp_valid  out  N_REQ         one-hot, single-cycle result strobe
//  rsp_id     out  ID_W          index of the requester owning rsp_p
//  rsp_p      out  DATA_W        saturated Q8.24 product
//  rsp_sat    out  1             rsp_p was clamped (valid with rsp_valid)
//  busy       out  1             any product in flight
// BEHAVIOUR
//  Reset: all pipeline valid bits are 0, ptr=0, and rsp_valid=0, rsp_id=0,
//   rsp_p=0, rsp_sat=0, busy=0. req_ready is 0 while req_valid=0.
//  Arbitration (combinational): grant goes to the first i with req_valid[i]
//   set, scanning ptr, ptr+1, ... mod N_REQ. At most one req_ready bit is
//   high, and only when that requester's req_valid is high.
//   No backpressure: some request is always granted if any is valid.
//  ptr update: on a handshake edge, ptr <= (grant_idx+1) mod N_REQ.
//   Otherwise ptr holds.
//  Requesters must keep req_a, req_b and req_valid stable until granted.
//   A requester may drop req_valid before it is granted; this is legal.
//  Pipeline: operands and ID are captured at the handshake edge t.
//   The full 2*DATA_W signed product is formed, then shifted right
//   arithmetically by FRAC_BITS (floor rounding).
//   The shifted value is saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]:
//   0x80000000 / 0x7FFFFFFF at default widths.
//   rsp_sat=1 iff clamping occurred.
//  Latency: rsp_valid[id], rsp_id, rsp_p and rsp_sat are registered outputs.
//   They are high or valid for exactly the one cycle after edge t+PIPE_STAGES.
//   Back-to-back grants give back-to-back responses in grant order.
//  rsp_p, rsp_id and rsp_sat hold their last value when rsp_valid=0.
//  busy=1 iff any pipeline stage holds a valid product. A grant in the
//   current cycle does not count until its capture edge.
//  Requesters must accept rsp_valid in the cycle it is asserted; there is no
//   response stall.
//  Reset mid-operation: all in-flight products are discarded and no
//   rsp_valid is emitted for them. ptr returns to 0.
//  Boundaries:
//   - Only one requester valid: it is granted every cycle, so it achieves
//     full throughput.
//   - ptr wraps from N_REQ-1 to 0.
//   - Simultaneous response and new grant in the same cycle are independent.
//   - -1.0 x -1.0 = +1.0 exactly. -128.0 x -128.0 saturates to max.
// TESTING
//  1 Reset: rst_n=0 mid-burst with 2 products in flight -> rsp_valid stays 0,
//    busy=0, ptr=0 after release.
//  2 Single op: req 1, a=0x02000000 (2.0), b=0xFE800000 (-1.5) ->
//    rsp_valid=4'b0010, rsp_id=1, rsp_p=0xFD000000 (-3.0), rsp_sat=0,
//    exactly PIPE_STAGES edges after handshake.
//  3 Round-robin: all 4 valid continuously for 8 cycles -> grant order
//    0,1,2,3,0,1,2,3. Responses follow in the same order, one per cycle.
//  4 Saturation: a=b=0x7F000000 (127.0) -> rsp_p=0x7FFFFFFF, rsp_sat=1.
//    a=0x80000000, b=0x02000000 -> rsp_p=0x80000000, rsp_sat=1.
//  5 Floor rounding: a=0xFFFFFFFF (-2^-24), b=0x00800000 (0.5) ->
//    rsp_p=0xFFFFFFFF, rsp_sat=0.
//  6 Fairness with gaps: req0 and req2 valid, ptr=1 -> req2 granted first,
//    then req0. req2 dropping valid before grant -> no response for req2.
//    Scoreboard checks all tags and values.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin shared Q-format signed multiplier: arbitrates N_REQ requesters, returns tagged, saturated products.
// Latency: PIPE_STAGES edges from handshake to registered response; one multiply per cycle.
// Backpressure: none; some valid request is always granted and responses cannot stall.
module mul_share_arbiter #(
    parameter int DATA_W      = 32,
    parameter int FRAC_BITS   = 24,
    parameter int N_REQ       = 4,
    parameter int PIPE_STAGES = 2,
    parameter int ID_W        = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_a,
    input  logic [N_REQ*DATA_W-1:0]   req_b,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_p,
    output logic                      rsp_sat,
    output logic                      busy
);

    localparam int LAST = PIPE_STAGES - 1;

    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              grant_vld;
    logic [ID_W-1:0]   grant_idx;

    logic              cap_vld_q, cap_vld_d;
    logic [DATA_W-1:0] cap_a_q, cap_a_d;
    logic [DATA_W-1:0] cap_b_q, cap_b_d;
    logic [ID_W-1:0]   cap_id_q, cap_id_d;

    logic signed [2*DATA_W-1:0] prod_full;
    logic signed [2*DATA_W-1:0] prod_shr;
    logic [DATA_W:0]            prod_hi;
    logic [DATA_W-1:0]          sat_p;
    logic                       sat_flag;

    logic [PIPE_STAGES-1:0] res_vld_q, res_vld_d;
    logic [PIPE_STAGES-1:0] res_sat_q, res_sat_d;
    logic [DATA_W-1:0]      res_p_q  [PIPE_STAGES];
    logic [DATA_W-1:0]      res_p_d  [PIPE_STAGES];
    logic [ID_W-1:0]        res_id_q [PIPE_STAGES];
    logic [ID_W-1:0]        res_id_d [PIPE_STAGES];

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(ptr_q) + k) % N_REQ]) begin
                grant_vld = 1'b1;
                grant_idx = ID_W'((int'(ptr_q) + k) % N_REQ);
            end
        end
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
        ptr_d = grant_vld ? ID_W'((int'(grant_idx) + 1) % N_REQ) : ptr_q;
    end

    always_comb begin
        cap_vld_d = grant_vld;
        cap_a_d   = grant_vld ? req_a[grant_idx*DATA_W +: DATA_W] : cap_a_q;
        cap_b_d   = grant_vld ? req_b[grant_idx*DATA_W +: DATA_W] : cap_b_q;
        cap_id_d  = grant_vld ? grant_idx : cap_id_q;
    end

    // Arithmetic shift floors; the result fits iff the top DATA_W+1 bits agree.
    always_comb begin
        prod_full = (2*DATA_W)'($signed(cap_a_q)) * (2*DATA_W)'($signed(cap_b_q));
        prod_shr  = prod_full >>> FRAC_BITS;
        prod_hi   = prod_shr[2*DATA_W-1:DATA_W-1];
        sat_flag  = !((&prod_hi) || (~|prod_hi));
        if (!sat_flag) begin
            sat_p = prod_shr[DATA_W-1:0];
        end else if (prod_hi[DATA_W]) begin
            sat_p = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_p = {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // Data registers only load on a valid entry so the outputs hold when idle.
    always_comb begin
        res_vld_d[0] = cap_vld_q;
        res_p_d[0]   = cap_vld_q ? sat_p    : res_p_q[0];
        res_id_d[0]  = cap_vld_q ? cap_id_q : res_id_q[0];
        res_sat_d[0] = cap_vld_q ? sat_flag : res_sat_q[0];
        for (int k = 1; k < PIPE_STAGES; k++) begin
            res_vld_d[k] = res_vld_q[k-1];
            res_p_d[k]   = res_vld_q[k-1] ? res_p_q[k-1]   : res_p_q[k];
            res_id_d[k]  = res_vld_q[k-1] ? res_id_q[k-1]  : res_id_q[k];
            res_sat_d[k] = res_vld_q[k-1] ? res_sat_q[k-1] : res_sat_q[k];
        end
    end

    always_comb begin
        busy = cap_vld_q;
        for (int k = 0; k < LAST; k++) begin
            busy = busy | res_vld_q[k];
        end
        rsp_valid = '0;
        if (res_vld_q[LAST]) begin
            rsp_valid[res_id_q[LAST]] = 1'b1;
        end
        rsp_id  = res_id_q[LAST];
        rsp_p   = res_p_q[LAST];
        rsp_sat = res_sat_q[LAST];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cap_vld_q <= 1'b0;
            cap_a_q   <= '0;
            cap_b_q   <= '0;
            cap_id_q  <= '0;
            res_vld_q <= '0;
            res_sat_q <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                res_p_q[k]  <= '0;
                res_id_q[k] <= '0;
            end
        end else begin
            ptr_q     <= ptr_d;
            cap_vld_q <= cap_vld_d;
            cap_a_q   <= cap_a_d;
            cap_b_q   <= cap_b_d;
            cap_id_q  <= cap_id_d;
            res_vld_q <= res_vld_d;
            res_sat_q <= res_sat_d;
            for (int k = 0; k < PIPE_STAGES; k++) begin
                res_p_q[k]  <= res_p_d[k];
                res_id_q[k] <= res_id_d[k];
            end
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter at default parameters (Q8.24, 4 requesters, 2-edge latency).
module tb_mul_share_arbiter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;
    logic [3:0]   rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_p;
    logic         rsp_sat;
    logic         busy;

    int errors = 0;
    int checks = 0;

    mul_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .rsp_sat(rsp_sat), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
    endtask

    task automatic test_reset();
        logic seen;
        tick(); tick();
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
        checks++; if (rsp_p !== 32'h0) begin errors++; $display("FAIL reset_rsp_p got=%h exp=00000000", rsp_p); end
        checks++; if (rsp_sat !== 1'b0) begin errors++; $display("FAIL reset_rsp_sat got=%b exp=0", rsp_sat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        rst_n = 1'b1;
        tick();
        // Two products in flight, then reset mid-burst.
        req_valid = 4'b0001;
        req_a[31:0] = 32'h01000000;
        req_b[31:0] = 32'h01000000;
        tick(); tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL burst_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        clear_reqs();
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL midreset_rsp_valid got=%b exp=0000", rsp_valid); end
        tick(); tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL postreset_quiet got=%b exp=0", seen); end
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL postreset_ptr_grant got=%b exp=0001", req_ready); end
        clear_reqs();
        #1;
    endtask

    task automatic test_single_op();
        req_valid = 4'b0010;
        req_a[63:32] = 32'h02000000;
        req_b[63:32] = 32'hFE800000;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got=%b exp=0010", req_ready); end
        tick();
        clear_reqs();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early1 got=%b exp=0000", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_early2 got=%b exp=0000", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL single_rsp_valid got=%b exp=0010", rsp_valid); end
        checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL single_rsp_id got=%0d exp=1", rsp_id); end
        checks++; if (rsp_p !== 32'hFD000000) begin errors++; $display("FAIL single_rsp_p got=%h exp=fd000000", rsp_p); end
        checks++; if (rsp_sat !== 1'b0) begin errors++; $display("FAIL single_rsp_sat got=%b exp=0", rsp_sat); end
        tick();
        checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL single_strobe_len got=%b exp=0000", rsp_valid); end
        checks++; if (rsp_p !== 32'hFD000000) begin errors++; $display("FAIL single_hold_p got=%h exp=fd000000", rsp_p); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_p;
        logic [3:0]  exp_v;
        // Park ptr at 0 by granting requester 3 alone, then drain.
        req_valid = 4'b1000;
        tick();
        clear_reqs();
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'(i + 1) << 24;
            req_b[i*32 +: 32] = 32'h02000000;
        end
        req_valid = 4'b1111;
        #1;
        for (int c = 0; c <= 10; c++) begin
            if (c >= 3) begin
                exp_v = 4'b0001 << ((c - 3) % 4);
                exp_p = 32'((((c - 3) % 4) + 1) * 2) << 24;
                checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=%b", c - 3, rsp_valid, exp_v); end
                checks++; if (rsp_p !== exp_p) begin errors++; $display("FAIL rr_rsp_p[%0d] got=%h exp=%h", c - 3, rsp_p, exp_p); end
            end else begin
                checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL rr_idle[%0d] got=%b exp=0000", c, rsp_valid); end
            end
            if (c < 8) begin
                exp_v = 4'b0001 << (c % 4);
                checks++; if (req_ready !== exp_v) begin errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, req_ready, exp_v); end
            end else if (c == 8) begin
                clear_reqs();
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        logic [31:0] va [4] = '{32'h7F000000, 32'h80000000, 32'hFF000000, 32'h80000000};
        logic [31:0] vb [4] = '{32'h7F000000, 32'h02000000, 32'hFF000000, 32'h80000000};
        logic [31:0] ep [4] = '{32'h7FFFFFFF, 32'h80000000, 32'h01000000, 32'h7FFFFFFF};
        logic        es [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        // Single requester streams back to back at full rate.
        for (int c = 0; c <= 6; c++) begin
            if (c >= 3) begin
                checks++; if (rsp_valid !== 4'b0100) begin errors++; $display("FAIL sat_rsp_valid[%0d] got=%b exp=0100", c - 3, rsp_valid); end
                checks++; if (rsp_p !== ep[c-3]) begin errors++; $display("FAIL sat_rsp_p[%0d] got=%h exp=%h", c - 3, rsp_p, ep[c-3]); end
                checks++; if (rsp_sat !== es[c-3]) begin errors++; $display("FAIL sat_flag[%0d] got=%b exp=%b", c - 3, rsp_sat, es[c-3]); end
            end
            if (c < 4) begin
                req_valid = 4'b0100;
                req_a[95:64] = va[c];
                req_b[95:64] = vb[c];
                #1;
                checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL sat_grant[%0d] got=%b exp=0100", c, req_ready); end
            end else if (c == 4) begin
                clear_reqs();
            end
            tick();
        end
    endtask

    task automatic test_floor();
        logic [31:0] va [2] = '{32'hFFFFFFFF, 32'h00000001};
        logic [31:0] vb [2] = '{32'h00800000, 32'h00800000};
        logic [31:0] ep [2] = '{32'hFFFFFFFF, 32'h00000000};
        for (int c = 0; c <= 4; c++) begin
            if (c >= 3) begin
                checks++; if (rsp_valid !== 4'b1000 || rsp_id !== 2'd3) begin errors++; $display("FAIL floor_rsp_tag[%0d] got=%b/%0d exp=1000/3", c - 3, rsp_valid, rsp_id); end
                checks++; if (rsp_p !== ep[c-3]) begin errors++; $display("FAIL floor_rsp_p[%0d] got=%h exp=%h", c - 3, rsp_p, ep[c-3]); end
                checks++; if (rsp_sat !== 1'b0) begin errors++; $display("FAIL floor_sat[%0d] got=%b exp=0", c - 3, rsp_sat); end
            end
            if (c < 2) begin
                req_valid = 4'b1000;
                req_a[127:96] = va[c];
                req_b[127:96] = vb[c];
                #1;
            end else if (c == 2) begin
                clear_reqs();
            end
            tick();
        end
    endtask

    task automatic test_fairness();
        logic [1:0]  eid [4] = '{2'd2, 2'd0, 2'd1, 2'd0};
        logic [31:0] ep  [4] = '{32'hFE000000, 32'h03000000, 32'h02000000, 32'h03000000};
        logic [3:0]  exp_v;
        int n = 0;
        // Grant requester 0 alone so ptr sits at 1, then drain.
        req_valid = 4'b0001;
        tick();
        clear_reqs();
        tick(); tick(); tick();
        req_a[31:0]  = 32'h01000000; req_b[31:0]  = 32'h03000000;
        req_a[63:32] = 32'h00400000; req_b[63:32] = 32'h08000000;
        req_a[95:64] = 32'hFF800000; req_b[95:64] = 32'h04000000;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid !== 4'b0000) begin
                if (n < 4) begin
                    exp_v = 4'b0001 << eid[n];
                    checks++; if (rsp_valid !== exp_v || rsp_id !== eid[n]) begin errors++; $display("FAIL fair_tag[%0d] got=%b/%0d exp=%b/%0d", n, rsp_valid, rsp_id, exp_v, eid[n]); end
                    checks++; if (rsp_p !== ep[n] || rsp_sat !== 1'b0) begin errors++; $display("FAIL fair_value[%0d] got=%h/%b exp=%h/0", n, rsp_p, rsp_sat, ep[n]); end
                end else begin
                    checks++; errors++;
                    $display("FAIL fair_extra_rsp got=%b exp=none", rsp_valid);
                end
                n++;
            end
            case (c)
                0: begin
                    req_valid = 4'b0101; #1;
                    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL fair_grant0 got=%b exp=0100", req_ready); end
                end
                1: begin
                    req_valid = 4'b0001; #1;
                    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_grant1 got=%b exp=0001", req_ready); end
                end
                2: begin
                    req_a[95:64] = 32'h01000000; req_b[95:64] = 32'h01000000;
                    req_valid = 4'b0111; #1;
                    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL fair_grant2 got=%b exp=0010", req_ready); end
                end
                3: begin
                    req_valid = 4'b0001; #1;
                    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL fair_grant3 got=%b exp=0001", req_ready); end
                end
                4: clear_reqs();
                default: ;
            endcase
            tick();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL fair_rsp_count got=%0d exp=4", n); end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_round_robin();
        test_saturation();
        test_floor();
        test_fairness();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
